sample_ram_reader: RTL and testbench

//  Readback engine for the capture block RAM (RAMB16_S9-style, 2048x9, synchronous read).

---
 rtl/sample_ram_reader.sv | 153 +++++++++++++++
 tb/tb_sample_ram_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_ram_reader.sv
// Readback engine for the capture block RAM: streams a window of samples in forward or
// reverse address order as a valid/ready word stream, with a small credit-limited FIFO.
module sample_ram_reader #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 9,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  reverse,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int FIFO_DEPTH = RAM_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH:0]     remaining;
    logic                    rev_q;
    logic                    ram_last;
    logic [RAM_LATENCY-1:0]  vld_p, last_p;
    logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
    logic                    fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_count;

    logic                    issue, issue_rev, done_nxt, push, pop;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic [ADDR_WIDTH:0]     issue_rem;
    logic [OCC_W-1:0]        occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_step(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic dir);
        return dir ? a - ADDR_WIDTH'(1) : a + ADDR_WIDTH'(1);
    endfunction

    assign busy      = (state != IDLE);
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
    assign out_last  = out_valid & fifo_last[rd_ptr];
    assign pop       = out_valid & out_ready;
    assign push      = vld_p[RAM_LATENCY-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Occupancy after this edge: FIFO words kept plus every read still on its way back.
    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_addr = addr;
        issue_rem  = remaining;
        issue_rev  = rev_q;
        done_nxt   = 1'b0;
        occ        = OCC_W'(fifo_count) + OCC_W'(ram_en) - OCC_W'(pop);
        for (int i = 0; i < RAM_LATENCY; i++) occ = occ + OCC_W'(vld_p[i]);
        case (state)
            IDLE: begin
                if (start && !done) begin
                    if (count == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        issue_addr = start_addr;
                        issue_rem  = count;
                        issue_rev  = reverse;
                        state_nxt  = (count == (ADDR_WIDTH+1)'(1)) ? DRAIN : FETCH;
                    end
                end
            end
            FETCH: begin
                if (remaining != '0 && occ < OCC_W'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (remaining == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            ram_en     <= 1'b0;
            ram_addr   <= '0;
            ram_last   <= 1'b0;
            addr       <= '0;
            remaining  <= '0;
            rev_q      <= 1'b0;
            vld_p      <= '0;
            last_p     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            done     <= done_nxt;
            ram_en   <= issue;
            ram_last <= issue && (issue_rem == (ADDR_WIDTH+1)'(1));
            if (issue) begin
                ram_addr  <= issue_addr;
                addr      <= addr_step(issue_addr, issue_rev);
                remaining <= issue_rem - (ADDR_WIDTH+1)'(1);
                rev_q     <= issue_rev;
            end
            // RAM return pipeline: tag slot k marks a read issued k+1 edges ago.
            vld_p[0]  <= ram_en;
            last_p[0] <= ram_last;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_rdata;
            fifo_last[wr_ptr] <= last_p[RAM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_sample_ram_reader.sv
// Randomized scoreboard bench for sample_ram_reader: a RAM model, a ready driver,
// a stimulus process that queues expected words/addresses, and a decoupled monitor.
module tb_sample_ram_reader;

    localparam int AW     = 11;
    localparam int DW     = 9;
    localparam int LAT    = 1;
    localparam int DEPTH  = LAT + 2;
    localparam int NWORDS = 1 << AW;

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [DW-1:0] data_t;

    logic  clock;
    logic  reset, start, reverse, busy, done, ram_en, out_valid, out_ready, out_last;
    addr_t start_addr, ram_addr;
    cnt_t  count;
    data_t ram_rdata, out_data;

    sample_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .count(count), .reverse(reverse), .busy(busy), .done(done),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM model: synchronous read, LAT edges from sampled enable to data
    data_t mem     [NWORDS];
    data_t rd_pipe [LAT];
    always @(posedge clock) begin
        if (ram_en) rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int duty = 100;
    int acc_cnt = 0, issued = 0, accepted = 0, done_cnt = 0;
    bit expect_done = 0, held_valid = 0, prev_done = 0;
    data_t held_data;
    logic  held_last;
    logic [DW:0] exp_q [$];
    addr_t       addr_q [$];
    logic [DW:0] mon_e;
    addr_t       mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_done"},      32'(done),      0);
        check({tag, "_ram_en"},    32'(ram_en),    0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_last"},  32'(out_last),  0);
        check({tag, "_ram_addr"},  32'(ram_addr),  0);
        check({tag, "_out_data"},  32'(out_data),  0);
    endtask

    // Reference: word k of a transfer comes from (start +/- k) mod 2**AW; last flags word count-1.
    task automatic start_xfer(input addr_t sa, input int cnt, input logic rev);
        addr_t a;
        a = sa;
        for (int k = 0; k < cnt; k++) begin
            exp_q.push_back({1'(k == cnt - 1), mem[a]});
            addr_q.push_back(a);
            a = rev ? a - addr_t'(1) : a + addr_t'(1);
        end
        start      = 1'b1;
        start_addr = sa;
        count      = cnt_t'(cnt);
        reverse    = rev;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit poke);
        bit got;
        got = 0;
        for (int k = 0; k < budget && !got; k++) begin
            tick();
            start = 1'b0;
            if (done) got = 1;
            else if (poke && (k % 97) == 50) begin
                start      = 1'b1;
                start_addr = addr_t'($urandom);
                count      = cnt_t'(5);
                reverse    = 1'b1;
            end
        end
        if (!got) begin
            report_fail("done_timeout", 32'(budget), 0);
            start = 1'b0;
            return;
        end
        check("busy_at_done", 32'(busy), 0);
        if (poke) begin
            start = 1'b1;
            count = cnt_t'(3);
        end
        tick();
        start = 1'b0;
        check("done_one_cycle", 32'(done), 0);
        check("words_drained", 32'(exp_q.size()), 0);
        check("addrs_drained", 32'(addr_q.size()), 0);
        if (poke) begin
            check("start_on_done_busy", 32'(busy), 0);
            tick();
            check("start_on_done_ram_en", 32'(ram_en), 0);
            check("start_on_done_busy2", 32'(busy), 0);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = ($urandom_range(0, 99) < duty);
        end
    end

    // Monitor: samples at the falling edge, so a word with valid&ready here is taken next edge
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_done  = 0;
                held_valid = 0;
                continue;
            end
            if (done) begin
                done_cnt++;
                if (prev_done) report_fail("done_width", 2, 1);
            end
            prev_done = done;
            if (expect_done) begin
                check("done_after_last", 32'(done), 1);
                check("busy_after_last", 32'(busy), 0);
                expect_done = 0;
            end
            if (ram_en) begin
                issued++;
                if (addr_q.size() == 0) report_fail("spurious_ram_en", 32'(ram_addr), 0);
                else begin
                    mon_a = addr_q.pop_front();
                    check("ram_addr", 32'(ram_addr), 32'(mon_a));
                end
            end
            if (out_valid) begin
                if (held_valid) begin
                    check("stall_data", 32'(out_data), 32'(held_data));
                    check("stall_last", 32'(out_last), 32'(held_last));
                end
                if (out_ready) begin
                    accepted++;
                    acc_cnt++;
                    held_valid = 0;
                    if (exp_q.size() == 0) report_fail("unexpected_word", 32'(out_data), 0);
                    else begin
                        mon_e = exp_q.pop_front();
                        check("out_data", 32'(out_data), 32'(mon_e[DW-1:0]));
                        check("out_last", 32'(out_last), 32'(mon_e[DW]));
                        if (mon_e[DW]) expect_done = 1;
                    end
                end else begin
                    held_valid = 1;
                    held_data  = out_data;
                    held_last  = out_last;
                end
            end else if (held_valid) begin
                report_fail("valid_dropped", 0, 1);
                held_valid = 0;
            end
            check("outstanding_le_depth", 32'((issued - accepted) <= DEPTH), 1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        addr_t sa;
        reset      = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        reverse    = 1'b0;
        for (int i = 0; i < NWORDS; i++) mem[i] = data_t'(i);
        #12;
        check_zero("por");
        tick();
        reset = 1'b0;
        tick();

        // T1: forward, first-valid latency
        duty = 100;
        start_xfer(addr_t'(16'h010), 4, 1'b0);
        check("t1_ram_en", 32'(ram_en), 1);
        check("t1_ram_addr", 32'(ram_addr), 32'h010);
        check("t1_busy", 32'(busy), 1);
        repeat (LAT) tick();
        check("t1_not_yet_valid", 32'(out_valid), 0);
        tick();
        check("t1_first_valid", 32'(out_valid), 1);
        check("t1_first_data", 32'(out_data), 32'h010);
        wait_done(100, 0);

        // T2: reverse across address 0
        for (int i = 0; i < NWORDS; i++) mem[i] = data_t'($urandom);
        start_xfer(addr_t'(16'h001), 4, 1'b1);
        wait_done(100, 0);

        // T3: back-pressure, then a handful of random transfers
        duty = 30;
        start_xfer(addr_t'($urandom), 16, 1'($urandom_range(0, 1)));
        wait_done(16 * 40 + 50, 0);
        for (int t = 0; t < 6; t++) begin
            int c;
            c    = $urandom_range(1, 40);
            duty = $urandom_range(20, 100);
            start_xfer(addr_t'($urandom), c, 1'($urandom_range(0, 1)));
            wait_done(c * 40 + 50, 0);
        end

        // T4: zero-length request
        duty = 100;
        d0 = done_cnt;
        start_xfer(addr_t'($urandom), 0, 1'b0);
        check("t4_done", 32'(done), 1);
        check("t4_busy", 32'(busy), 0);
        check("t4_ram_en", 32'(ram_en), 0);
        repeat (5) tick();
        check("t4_done_cleared", 32'(done), 0);
        check("t4_done_count", 32'(done_cnt - d0), 1);

        // T5: reset after five words, then a clean 2-word stream
        acc_cnt = 0;
        start_xfer(addr_t'($urandom), 20, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 200 && acc_cnt < 5; k++) tick();
        if (acc_cnt < 5) report_fail("t5_words_timeout", 32'(acc_cnt), 5);
        #1;
        reset = 1'b1;
        #1;
        check_zero("t5_async");
        exp_q.delete();
        addr_q.delete();
        expect_done = 0;
        issued      = 0;
        accepted    = 0;
        d0 = done_cnt;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t5_no_done", 32'(done_cnt - d0), 0);
        check("t5_idle", 32'(busy), 0);
        sa = addr_t'($urandom);
        start_xfer(sa, 2, 1'($urandom_range(0, 1)));
        wait_done(60, 0);

        // T6: full sweep with ignored starts while busy and on the done cycle
        start_xfer(addr_t'($urandom), NWORDS, 1'b0);
        wait_done(NWORDS + 300, 1);
        repeat (4) tick();
        check("final_busy", 32'(busy), 0);
        check("final_valid", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
